// File: rtl/l15_anycoredecoder_pkg.sv
// Shared definitions for the anycore <-> L1.5 request bridge.
// Holds the PCX request/size codes, request-class and arbiter encodings,
// slot payload structs and the byte-swap helper used by both directions.
package l15_anycoredecoder_pkg;

  localparam int unsigned PADDR_W  = 40;
  localparam int unsigned DATA_W   = 64;
  localparam int unsigned RQTYPE_W = 5;
  localparam int unsigned SIZE_W   = 3;

  localparam logic [RQTYPE_W-1:0] PCX_REQTYPE_LOAD  = 5'b00000;
  localparam logic [RQTYPE_W-1:0] PCX_REQTYPE_STORE = 5'b00001;
  localparam logic [RQTYPE_W-1:0] PCX_REQTYPE_IFILL = 5'b10000;

  localparam logic [SIZE_W-1:0] PCX_SZ_1B  = 3'b000;
  localparam logic [SIZE_W-1:0] PCX_SZ_2B  = 3'b001;
  localparam logic [SIZE_W-1:0] PCX_SZ_4B  = 3'b010;
  localparam logic [SIZE_W-1:0] PCX_SZ_8B  = 3'b011;
  localparam logic [SIZE_W-1:0] PCX_SZ_16B = 3'b111;

  // Request classes; arbitration priority is STORE > LOAD > IFILL.
  typedef enum logic [1:0] {
    CLS_IFILL = 2'd0,
    CLS_LOAD  = 2'd1,
    CLS_STORE = 2'd2
  } req_cls_e;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_SEND = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [PADDR_W-1:0] addr;
  } line_req_t;

  typedef struct packed {
    logic [PADDR_W-1:0] addr;
    logic [DATA_W-1:0]  data;
    logic [1:0]         size;
  } st_req_t;

  localparam int unsigned LINE_REQ_W = $bits(line_req_t);
  localparam int unsigned ST_REQ_W   = $bits(st_req_t);

  // Byte 0 moves to bits 63:56 (little-endian core -> big-endian PCX).
  function automatic logic [DATA_W-1:0] byteswap64(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[8*(7-i) +: 8] = d[8*i +: 8];
    end
    return r;
  endfunction

  // Fill all 64 bits with copies of the LSB-justified store operand.
  function automatic logic [DATA_W-1:0] store_replicate(input logic [DATA_W-1:0] d,
                                                        input logic [1:0]        sz);
    logic [DATA_W-1:0] r;
    case (sz)
      2'd0:    r = {8{d[7:0]}};
      2'd1:    r = {4{d[15:0]}};
      2'd2:    r = {2{d[31:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/l15_anycoredecoder_req_slot.sv
// One-entry request holding register.
// Ports: clk/rst; cap_i captures payload_i when empty; clr_i empties the slot;
//        full_o flags a held request; payload_o is the held payload.
module l15_anycoredecoder_req_slot #(
  parameter int unsigned W = 40
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cap_i,
  input  logic         clr_i,
  input  logic [W-1:0] payload_i,
  output logic         full_o,
  output logic [W-1:0] payload_o
);

  logic         full_q, full_d;
  logic [W-1:0] payload_q, payload_d;

  // A capture only lands in an empty slot; a pulse against a full slot is dropped.
  always_comb begin
    full_d    = full_q;
    payload_d = payload_q;
    if (clr_i) begin
      full_d = 1'b0;
    end
    if (cap_i && !full_q) begin
      full_d    = 1'b1;
      payload_d = payload_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q    <= 1'b0;
      payload_q <= '0;
    end else begin
      full_q    <= full_d;
      payload_q <= payload_d;
    end
  end

  assign full_o    = full_q;
  assign payload_o = payload_q;

endmodule

// File: rtl/l15_anycoredecoder.sv
// Request-side bridge anycore -> L1.5.
// Captures I-miss, load-miss and store requests into one slot per class and
// issues them one at a time as PCX transducer requests (STORE > LOAD > IFILL).
// Ports: anycore_ic2mem_* / anycore_dc2mem_* request inputs; icstall/ldstall
//        back-pressure; l15_ifill_ret/l15_ld_ret/l15_st_ack return pulses;
//        anycoredecoder_l15_* request outputs with l15_anycoredecoder_ack;
//        anycoredecoder_err_unexp_ret sticky unexpected-return flag.
module l15_anycoredecoder
  import l15_anycoredecoder_pkg::*;
#(
  parameter int unsigned IC_LINE_LSB = 5,
  parameter int unsigned DC_LINE_LSB = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                anycore_ic2mem_reqvalid,
  input  logic [PADDR_W-1:0]  anycore_ic2mem_reqaddr,
  input  logic                anycore_dc2mem_ldvalid,
  input  logic [PADDR_W-1:0]  anycore_dc2mem_ldaddr,
  input  logic                anycore_dc2mem_stvalid,
  input  logic [PADDR_W-1:0]  anycore_dc2mem_staddr,
  input  logic [DATA_W-1:0]   anycore_dc2mem_stdata,
  input  logic [1:0]          anycore_dc2mem_stsize,
  output logic                anycore_mem2ic_icstall,
  output logic                anycore_mem2dc_ldstall,
  input  logic                l15_ifill_ret,
  input  logic                l15_ld_ret,
  input  logic                l15_st_ack,
  output logic                anycoredecoder_l15_val,
  output logic [RQTYPE_W-1:0] anycoredecoder_l15_rqtype,
  output logic [PADDR_W-1:0]  anycoredecoder_l15_address,
  output logic [DATA_W-1:0]   anycoredecoder_l15_data,
  output logic [SIZE_W-1:0]   anycoredecoder_l15_size,
  input  logic                l15_anycoredecoder_ack,
  output logic                anycoredecoder_err_unexp_ret
);

  localparam logic [PADDR_W-1:0] IC_MASK = ~((PADDR_W'(1) << IC_LINE_LSB) - PADDR_W'(1));
  localparam logic [PADDR_W-1:0] DC_MASK = ~((PADDR_W'(1) << DC_LINE_LSB) - PADDR_W'(1));

  arb_state_e          state_q, state_d;
  req_cls_e            sel_q, sel_d;
  logic                val_q, val_d;
  logic [RQTYPE_W-1:0] rqtype_q, rqtype_d;
  logic [PADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [SIZE_W-1:0]   size_q, size_d;
  logic                err_q, err_d;
  logic                ic_out_q, ic_out_d;
  logic                ld_out_q, ld_out_d;
  logic                st_out_q, st_out_d;

  logic      ic_full, ld_full, st_full;
  logic      ic_clr, ld_clr, st_clr;
  logic      ic_cap, ld_cap, st_cap;
  line_req_t ic_in, ld_in, ic_req, ld_req;
  st_req_t   st_in, st_req;

  // A return pulse frees its class in the same cycle a new request may be captured.
  assign ic_cap = anycore_ic2mem_reqvalid & ~ic_full & (~ic_out_q | l15_ifill_ret);
  assign ld_cap = anycore_dc2mem_ldvalid  & ~ld_full & (~ld_out_q | l15_ld_ret);
  assign st_cap = anycore_dc2mem_stvalid  & ~st_full;

  assign ic_in.addr  = anycore_ic2mem_reqaddr;
  assign ld_in.addr  = anycore_dc2mem_ldaddr;
  assign st_in.addr  = anycore_dc2mem_staddr;
  assign st_in.data  = anycore_dc2mem_stdata;
  assign st_in.size  = anycore_dc2mem_stsize;

  l15_anycoredecoder_req_slot #(.W(LINE_REQ_W)) u_ic_slot (
    .clk       (clk),
    .rst       (rst),
    .cap_i     (ic_cap),
    .clr_i     (ic_clr),
    .payload_i (ic_in),
    .full_o    (ic_full),
    .payload_o (ic_req)
  );

  l15_anycoredecoder_req_slot #(.W(LINE_REQ_W)) u_ld_slot (
    .clk       (clk),
    .rst       (rst),
    .cap_i     (ld_cap),
    .clr_i     (ld_clr),
    .payload_i (ld_in),
    .full_o    (ld_full),
    .payload_o (ld_req)
  );

  l15_anycoredecoder_req_slot #(.W(ST_REQ_W)) u_st_slot (
    .clk       (clk),
    .rst       (rst),
    .cap_i     (st_cap),
    .clr_i     (st_clr),
    .payload_i (st_in),
    .full_o    (st_full),
    .payload_o (st_req)
  );

  // Arbiter: pick an eligible slot in IDLE, hold it on the bus until ack in SEND.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    val_d    = val_q;
    rqtype_d = rqtype_q;
    addr_d   = addr_q;
    data_d   = data_q;
    size_d   = size_q;
    ic_clr   = 1'b0;
    ld_clr   = 1'b0;
    st_clr   = 1'b0;
    ic_out_d = ic_out_q & ~l15_ifill_ret;
    ld_out_d = ld_out_q & ~l15_ld_ret;
    st_out_d = st_out_q & ~l15_st_ack;
    err_d    = err_q | (l15_ifill_ret & ~ic_out_q) | (l15_ld_ret & ~ld_out_q)
                     | (l15_st_ack & ~st_out_q);

    case (state_q)
      ARB_IDLE: begin
        if (st_full && !st_out_q) begin
          sel_d    = CLS_STORE;
          rqtype_d = PCX_REQTYPE_STORE;
          addr_d   = st_req.addr;
          data_d   = byteswap64(store_replicate(st_req.data, st_req.size));
          size_d   = {1'b0, st_req.size};
          val_d    = 1'b1;
          state_d  = ARB_SEND;
        end else if (ld_full && !ld_out_q) begin
          sel_d    = CLS_LOAD;
          rqtype_d = PCX_REQTYPE_LOAD;
          addr_d   = ld_req.addr & DC_MASK;
          data_d   = '0;
          size_d   = PCX_SZ_16B;
          val_d    = 1'b1;
          state_d  = ARB_SEND;
        end else if (ic_full && !ic_out_q) begin
          sel_d    = CLS_IFILL;
          rqtype_d = PCX_REQTYPE_IFILL;
          addr_d   = ic_req.addr & IC_MASK;
          data_d   = '0;
          size_d   = PCX_SZ_16B;
          val_d    = 1'b1;
          state_d  = ARB_SEND;
        end
      end
      ARB_SEND: begin
        if (l15_anycoredecoder_ack) begin
          val_d   = 1'b0;
          state_d = ARB_IDLE;
          case (sel_q)
            CLS_STORE: begin st_clr = 1'b1; st_out_d = 1'b1; end
            CLS_LOAD:  begin ld_clr = 1'b1; ld_out_d = 1'b1; end
            CLS_IFILL: begin ic_clr = 1'b1; ic_out_d = 1'b1; end
            default:   ;
          endcase
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      sel_q    <= CLS_IFILL;
      val_q    <= 1'b0;
      rqtype_q <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      size_q   <= '0;
      err_q    <= 1'b0;
      ic_out_q <= 1'b0;
      ld_out_q <= 1'b0;
      st_out_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      val_q    <= val_d;
      rqtype_q <= rqtype_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      size_q   <= size_d;
      err_q    <= err_d;
      ic_out_q <= ic_out_d;
      ld_out_q <= ld_out_d;
      st_out_q <= st_out_d;
    end
  end

  assign anycore_mem2ic_icstall       = ic_full | ic_out_q;
  assign anycore_mem2dc_ldstall       = ld_full | ld_out_q;
  assign anycoredecoder_l15_val       = val_q;
  assign anycoredecoder_l15_rqtype    = rqtype_q;
  assign anycoredecoder_l15_address   = addr_q;
  assign anycoredecoder_l15_data      = data_q;
  assign anycoredecoder_l15_size      = size_q;
  assign anycoredecoder_err_unexp_ret = err_q;

endmodule

// File: tb/tb_l15_anycoredecoder.sv
// Bench for l15_anycoredecoder: directed scenarios followed by a randomized
// phase where the bench plays the L1.5 (random ack / return delays).
module tb_l15_anycoredecoder;

  localparam logic [4:0] RQ_LOAD  = 5'b00000;
  localparam logic [4:0] RQ_STORE = 5'b00001;
  localparam logic [4:0] RQ_IFILL = 5'b10000;

  logic        clk;
  logic        rst;
  logic        ic_valid, ld_valid, st_valid;
  logic [39:0] ic_addr, ld_addr, st_addr;
  logic [63:0] st_data;
  logic [1:0]  st_size;
  logic        icstall, ldstall;
  logic        ifill_ret, ld_ret, st_ack;
  logic        val;
  logic [4:0]  rqtype;
  logic [39:0] addr;
  logic [63:0] data;
  logic [2:0]  size;
  logic        ack;
  logic        err;

  int total = 0;
  int bad   = 0;

  l15_anycoredecoder dut (
    .clk                          (clk),
    .rst                          (rst),
    .anycore_ic2mem_reqvalid      (ic_valid),
    .anycore_ic2mem_reqaddr       (ic_addr),
    .anycore_dc2mem_ldvalid       (ld_valid),
    .anycore_dc2mem_ldaddr        (ld_addr),
    .anycore_dc2mem_stvalid       (st_valid),
    .anycore_dc2mem_staddr        (st_addr),
    .anycore_dc2mem_stdata        (st_data),
    .anycore_dc2mem_stsize        (st_size),
    .anycore_mem2ic_icstall       (icstall),
    .anycore_mem2dc_ldstall       (ldstall),
    .l15_ifill_ret                (ifill_ret),
    .l15_ld_ret                   (ld_ret),
    .l15_st_ack                   (st_ack),
    .anycoredecoder_l15_val       (val),
    .anycoredecoder_l15_rqtype    (rqtype),
    .anycoredecoder_l15_address   (addr),
    .anycoredecoder_l15_data      (data),
    .anycoredecoder_l15_size      (size),
    .l15_anycoredecoder_ack       (ack),
    .anycoredecoder_err_unexp_ret (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ic_valid  = 1'b0;
    ld_valid  = 1'b0;
    st_valid  = 1'b0;
    ifill_ret = 1'b0;
    ld_ret    = 1'b0;
    st_ack    = 1'b0;
    ack       = 1'b0;
  endtask

  task automatic wait_val(input int budget, input string tag);
    int n;
    n = 0;
    while (val !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 64'(val), 64'd1);
  endtask

  task automatic check_req(input string tag, input logic [4:0] t, input logic [39:0] a,
                           input logic [63:0] d, input logic [2:0] s);
    chk({tag, "_rqtype"}, 64'(rqtype), 64'(t));
    chk({tag, "_addr"},   64'(addr),   64'(a));
    chk({tag, "_data"},   data,        d);
    chk({tag, "_size"},   64'(size),   64'(s));
  endtask

  // Output byte i (from the MSB end) is input byte (i mod operand-size).
  function automatic logic [63:0] exp_st_data(input logic [63:0] d, input logic [1:0] sz);
    logic [63:0] r;
    int nb;
    nb = 1 << sz;
    r  = '0;
    for (int i = 0; i < 8; i++) begin
      r[63-8*i -: 8] = d[8*(i % nb) +: 8];
    end
    return r;
  endfunction

  function automatic int cls_of(input logic [4:0] r);
    case (r)
      RQ_IFILL: return 0;
      RQ_LOAD:  return 1;
      RQ_STORE: return 2;
      default:  return -1;
    endcase
  endfunction

  // Random-phase model: per class (0=ifill,1=load,2=store) a pending request and an
  // outstanding flag, plus the exact bus fields that request must appear with.
  bit          pend  [3];
  bit          outs  [3];
  int          retcnt[3];
  logic [39:0] e_addr[3];
  logic [63:0] e_data[3];
  logic [2:0]  e_size[3];

  initial begin
    idle_inputs();
    ic_addr = '0; ld_addr = '0; st_addr = '0; st_data = '0; st_size = '0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_val",     64'(val),     64'd0);
    chk("rst_rqtype",  64'(rqtype),  64'd0);
    chk("rst_addr",    64'(addr),    64'd0);
    chk("rst_data",    data,         64'd0);
    chk("rst_size",    64'(size),    64'd0);
    chk("rst_icstall", 64'(icstall), 64'd0);
    chk("rst_ldstall", 64'(ldstall), 64'd0);
    chk("rst_err",     64'(err),     64'd0);

    // Single IFILL
    ic_valid = 1'b1; ic_addr = 40'h00_8000_0013;
    tick();
    idle_inputs();
    chk("if_stall_cap", 64'(icstall), 64'd1);
    chk("if_val_early", 64'(val),     64'd0);
    tick();
    chk("if_val", 64'(val), 64'd1);
    check_req("if", RQ_IFILL, 40'h00_8000_0000, 64'd0, 3'b111);
    tick();
    chk("if_val_hold", 64'(val), 64'd1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("if_val_drop", 64'(val),     64'd0);
    chk("if_out_stall", 64'(icstall), 64'd1);
    tick(); tick();
    chk("if_out_stall2", 64'(icstall), 64'd1);
    chk("if_no_resend",  64'(val),     64'd0);
    ifill_ret = 1'b1;
    tick();
    ifill_ret = 1'b0;
    chk("if_ret_stall", 64'(icstall), 64'd0);
    chk("if_ret_err",   64'(err),     64'd0);

    // Store 2B
    st_valid = 1'b1; st_addr = 40'h00_1000_0006; st_data = 64'h0123_4567_89AB_BEEF; st_size = 2'd1;
    tick();
    idle_inputs();
    tick();
    chk("st_val", 64'(val), 64'd1);
    check_req("st2", RQ_STORE, 40'h00_1000_0006, 64'hEFBE_EFBE_EFBE_EFBE, 3'b001);
    chk("st_icstall", 64'(icstall), 64'd0);
    chk("st_ldstall", 64'(ldstall), 64'd0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("st_val_drop", 64'(val), 64'd0);
    st_ack = 1'b1;
    tick();
    st_ack = 1'b0;
    chk("st_ack_err", 64'(err), 64'd0);

    // Same-cycle st + ld + ic: STORE, LOAD, IFILL order; STORE held 5 cycles
    st_valid = 1'b1; st_addr = 40'h00_2000_0003; st_data = 64'h0000_0000_0000_00A5; st_size = 2'd0;
    ld_valid = 1'b1; ld_addr = 40'h00_3000_001F;
    ic_valid = 1'b1; ic_addr = 40'h00_4000_003F;
    tick();
    idle_inputs();
    tick();
    chk("tri_st_val", 64'(val), 64'd1);
    check_req("tri_st", RQ_STORE, 40'h00_2000_0003, 64'hA5A5_A5A5_A5A5_A5A5, 3'b000);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("tri_st_hold_val", 64'(val), 64'd1);
      check_req("tri_st_hold", RQ_STORE, 40'h00_2000_0003, 64'hA5A5_A5A5_A5A5_A5A5, 3'b000);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("tri_gap", 64'(val), 64'd0);
    wait_val(4, "tri_ld_wait");
    check_req("tri_ld", RQ_LOAD, 40'h00_3000_0010, 64'd0, 3'b111);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("tri_gap2", 64'(val), 64'd0);
    wait_val(4, "tri_if_wait");
    check_req("tri_if", RQ_IFILL, 40'h00_4000_0020, 64'd0, 3'b111);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    ifill_ret = 1'b1; ld_ret = 1'b1; st_ack = 1'b1;
    tick();
    idle_inputs();
    chk("tri_ret_icstall", 64'(icstall), 64'd0);
    chk("tri_ret_ldstall", 64'(ldstall), 64'd0);
    chk("tri_ret_err",     64'(err),     64'd0);

    // Clear/capture overlap on the load class
    ld_valid = 1'b1; ld_addr = 40'h00_5000_0008;
    tick();
    idle_inputs();
    wait_val(4, "ov_ld1_wait");
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("ov_out_stall", 64'(ldstall), 64'd1);
    ld_ret = 1'b1; ld_valid = 1'b1; ld_addr = 40'h00_6000_0024;
    tick();
    idle_inputs();
    chk("ov_cap_stall", 64'(ldstall), 64'd1);
    wait_val(4, "ov_ld2_wait");
    check_req("ov_ld2", RQ_LOAD, 40'h00_6000_0020, 64'd0, 3'b111);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("ov_out_again", 64'(ldstall), 64'd1);
    chk("ov_err",       64'(err),     64'd0);
    ld_ret = 1'b1;
    tick();
    idle_inputs();
    chk("ov_free", 64'(ldstall), 64'd0);

    // Spurious store ack
    st_ack = 1'b1;
    tick();
    st_ack = 1'b0;
    chk("sp_err", 64'(err), 64'd1);
    chk("sp_val", 64'(val), 64'd0);
    chk("sp_addr_keep", 64'(addr), 64'(40'h00_6000_0020));
    tick();
    chk("sp_err_sticky", 64'(err), 64'd1);

    // Reset during SEND
    ic_valid = 1'b1; ic_addr = 40'h00_7000_0040;
    tick();
    idle_inputs();
    wait_val(4, "rs_wait");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rs_val",     64'(val),     64'd0);
    chk("rs_icstall", 64'(icstall), 64'd0);
    chk("rs_ldstall", 64'(ldstall), 64'd0);
    chk("rs_err",     64'(err),     64'd0);
    tick(); tick();
    chk("rs_lost", 64'(val), 64'd0);

    // Randomized phase against the class-level model
    for (int k = 0; k < 3; k++) begin
      pend[k] = 1'b0; outs[k] = 1'b0; retcnt[k] = 0;
      e_addr[k] = '0; e_data[k] = '0; e_size[k] = '0;
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      bit acked [3];
      int cls;
      logic [39:0] ra;
      logic [63:0] rd;
      logic [1:0]  rs;
      for (int k = 0; k < 3; k++) acked[k] = 1'b0;

      chk("rnd_icstall", 64'(icstall), 64'(pend[0] | outs[0]));
      chk("rnd_ldstall", 64'(ldstall), 64'(pend[1] | outs[1]));
      chk("rnd_err",     64'(err),     64'd0);

      idle_inputs();
      if (val === 1'b1) begin
        cls = cls_of(rqtype);
        chk("rnd_rqtype_known", 64'(cls >= 0), 64'd1);
        if (cls >= 0) begin
          chk("rnd_eligible", 64'(pend[cls] && !outs[cls]), 64'd1);
          chk("rnd_addr", 64'(addr), 64'(e_addr[cls]));
          chk("rnd_data", data, e_data[cls]);
          chk("rnd_size", 64'(size), 64'(e_size[cls]));
          if ($urandom_range(0, 2) == 0) begin
            ack = 1'b1;
            pend[cls]   = 1'b0;
            outs[cls]   = 1'b1;
            acked[cls]  = 1'b1;
            retcnt[cls] = int'($urandom_range(0, 6));
          end
        end
      end

      for (int k = 0; k < 3; k++) begin
        if (outs[k] && !acked[k]) begin
          if (retcnt[k] == 0) begin
            outs[k] = 1'b0;
            case (k)
              0: ifill_ret = 1'b1;
              1: ld_ret    = 1'b1;
              default: st_ack = 1'b1;
            endcase
          end else begin
            retcnt[k]--;
          end
        end
      end

      for (int k = 0; k < 3; k++) begin
        if (!pend[k] && !acked[k] && (k == 2 || !outs[k]) && $urandom_range(0, 2) == 0) begin
          ra = {8'($urandom), 32'($urandom)};
          rd = {32'($urandom), 32'($urandom)};
          rs = 2'($urandom);
          pend[k] = 1'b1;
          case (k)
            0: begin
              ic_valid = 1'b1; ic_addr = ra;
              e_addr[k] = ra & ~40'h1F; e_data[k] = '0; e_size[k] = 3'b111;
            end
            1: begin
              ld_valid = 1'b1; ld_addr = ra;
              e_addr[k] = ra & ~40'hF; e_data[k] = '0; e_size[k] = 3'b111;
            end
            default: begin
              st_valid = 1'b1; st_addr = ra; st_data = rd; st_size = rs;
              e_addr[k] = ra; e_data[k] = exp_st_data(rd, rs); e_size[k] = {1'b0, rs};
            end
          endcase
        end
      end
      tick();
    end
    idle_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
